// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_pkg;

    // Arbiter FSM states: one idle/grant state, three bus-owning busy
    // states and a single-cycle completion state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Read data returned to a requester whose transaction timed out.
    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

    // Requester identity as stored in the side / last_grant bits.
    localparam logic SIDE_FETCH = 1'b0;
    localparam logic SIDE_DATA  = 1'b1;

    localparam int WORD_ADDR_W = 30;
    localparam int MEM_ADDR_W  = 27;
    localparam int XFER_W      = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: fetch on req[0], data on req[1].
// A tie goes to the side that was not granted last; last_grant only
// moves when the owner of the bus actually takes the grant.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_grant;

    // One-hot grant, alternating on a tie.
    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = (last_grant == SIDE_DATA) ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    // Remember who was served; data is "last" out of reset so fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SIDE_DATA;
        end else if (take && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch reads and data reads/writes onto a single
// memory port. One transaction at a time; a busy transaction that sees no
// mem_ack for TIMEOUT cycles is completed with err and abort data.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_rreq,
    input  logic        d_wreq,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        err,
    output logic [26:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        mem_rreq,
    output logic        mem_wreq,
    input  logic        mem_ack
);

    // Counter holds 0..TIMEOUT-1; the last value marks the final busy cycle.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic             side_q;
    logic             err_q;
    logic [24:0]      addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             d_req;
    logic [1:0]       grant;
    logic             busy;
    logic             timed_out;
    logic             unused_addr_hi;

    // Word-address bits above the 27-bit byte bus are intentionally dropped.
    assign unused_addr_hi = ^{if_addr[29:25], d_addr[29:25]};

    assign d_req       = d_rreq | d_wreq;
    assign busy        = (state_q == FETCH) || (state_q == DREAD) || (state_q == DWRITE);
    assign timed_out   = busy && !mem_ack && (cnt_q == CNT_LAST);
    assign mem_address = {addr_q, 2'b00};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({d_req, if_req}),
        .take  (state_q == IDLE),
        .grant (grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus/handshake outputs; ack wins over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        mem_rreq = 1'b0;
        mem_wreq = 1'b0;
        if_done  = 1'b0;
        d_done   = 1'b0;
        err      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    state_d = FETCH;
                end else if (grant[1]) begin
                    state_d = d_wreq ? DWRITE : DREAD;
                end
            end
            FETCH, DREAD: begin
                mem_rreq = 1'b1;
                if (mem_ack || timed_out) begin
                    state_d = RESP;
                end
            end
            DWRITE: begin
                mem_wreq = 1'b1;
                if (mem_ack || timed_out) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if_done = (side_q == SIDE_FETCH);
                d_done  = (side_q == SIDE_DATA);
                err     = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the granted request, count busy cycles and capture read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            side_q         <= SIDE_FETCH;
            err_q          <= 1'b0;
            addr_q         <= '0;
            cnt_q          <= '0;
            mem_write_data <= '0;
            if_rdata       <= '0;
            d_rdata        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        side_q <= grant[1];
                        err_q  <= 1'b0;
                        cnt_q  <= '0;
                        addr_q <= grant[1] ? d_addr[24:0] : if_addr[24:0];
                        if (grant[1]) begin
                            mem_write_data <= d_wdata;
                        end
                    end
                end
                FETCH, DREAD, DWRITE: begin
                    if (mem_ack) begin
                        if (state_q == FETCH) begin
                            if_rdata <= mem_read_data;
                        end else if (state_q == DREAD) begin
                            d_rdata <= mem_read_data;
                        end
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                        if (state_q == FETCH) begin
                            if_rdata <= ABORT_DATA;
                        end else if (state_q == DREAD) begin
                            d_rdata <= ABORT_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-level reference model + scoreboard,
// directed scenarios followed by randomized concurrent fetch/data traffic.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [29:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_rreq;
    logic        d_wreq;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        err;
    logic [26:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_rreq;
    logic        mem_wreq;
    logic        mem_ack;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_rreq(d_rreq), .d_wreq(d_wreq), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .err(err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_rreq(mem_rreq), .mem_wreq(mem_wreq),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          side;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sbq[$];
    bit          grant_log[$];
    int          starts[2];
    int          force_k = 0;       // ack in busy cycle k; 0 = random, 99 = never
    bit          use_force_rd = 1'b0;
    logic [31:0] force_rd = '0;

    // Reference model + memory responder: predicts each grant from the
    // requests seen in the grant cycle, checks the bus, pushes the expected
    // completion, and drives mem_ack / mem_read_data.
    initial begin : model
        bit          pf, pd, pwr, busy, in_busy, trk, side, wr, last_served;
        logic [29:0] pfa, pda;
        logic [31:0] pwd, rd, ewd;
        logic [26:0] ea;
        logic [31:0] rmem[2];
        int          cyc, k, blen;
        exp_t        e;
        mem_ack = 1'b0; mem_read_data = '0;
        pf = 0; pd = 0; pwr = 0; pfa = '0; pda = '0; pwd = '0;
        last_served = 1'b1; in_busy = 0; trk = 0; cyc = 0; k = 0; blen = 0;
        rmem[0] = '0; rmem[1] = '0; side = 0; wr = 0; ea = '0; ewd = '0; rd = '0;
        starts[0] = 0; starts[1] = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_read_data = $urandom;
            if (rst) begin
                sbq.delete(); grant_log.delete();
                last_served = 1'b1; rmem[0] = '0; rmem[1] = '0;
                in_busy = 0; trk = 0;
            end else begin
                busy = mem_rreq | mem_wreq;
                if (busy && !in_busy) begin
                    check("req_pending", 32'(pf | pd), 32'd1);
                    side = (pf && pd) ? ~last_served : pd;
                    wr   = side && pwr;
                    ea   = side ? {pda[24:0], 2'b00} : {pfa[24:0], 2'b00};
                    ewd  = pwd;
                    k    = (force_k != 0) ? force_k : int'($urandom_range(1, TO + 2));
                    rd   = use_force_rd ? force_rd : $urandom;
                    e.side  = side;
                    e.err   = (k > TO);
                    e.rdata = wr ? rmem[side] : ((k > TO) ? 32'hDEADBEEF : rd);
                    rmem[side] = e.rdata;
                    sbq.push_back(e);
                    grant_log.push_back(side);
                    starts[side]++;
                    last_served = side;
                    in_busy = 1; trk = 1; cyc = 1; blen = 1;
                end else if (busy) begin
                    blen++; cyc++;
                end else if (in_busy) begin
                    in_busy = 0;
                    check("busy_len", 32'(blen), 32'((k < TO) ? k : TO));
                    cyc++;
                end else if (trk) begin
                    cyc++;
                end
                if (busy) begin
                    check("mem_address", 32'(mem_address), 32'(ea));
                    check("mem_rreq", 32'(mem_rreq), 32'(!wr));
                    check("mem_wreq", 32'(mem_wreq), 32'(wr));
                    if (wr) check("mem_write_data", mem_write_data, ewd);
                end
                if (trk && cyc == k) begin
                    mem_ack = 1'b1;
                    mem_read_data = rd;
                end
                if (trk && (cyc >= k || cyc > TO + 2)) begin
                    trk = 0;
                end else if (!trk && !busy && $urandom_range(0, 7) == 0) begin
                    mem_ack = 1'b1;  // stray ack outside a busy state
                end
            end
            pf = if_req; pd = d_rreq | d_wreq; pwr = d_wreq;
            pfa = if_addr; pda = d_addr; pwd = d_wdata;
        end
    end

    // Monitor: every done pulse is matched against the next expected completion.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_done || d_done) begin
                    check("single_done", 32'(if_done & d_done), 32'd0);
                    check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check("done_side", 32'(d_done), 32'(e.side));
                        check("done_err", 32'(err), 32'(e.err));
                        check("done_rdata", e.side ? d_rdata : if_rdata, e.rdata);
                    end
                end else if (err) begin
                    check("err_without_done", 32'(err), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          t_first, t_lat, t_rc, t_wc, t_ifd, t_dd, t_errc;
    logic [26:0] t_addr;
    logic [31:0] t_rdat;

    task automatic apply_reset();
        rst = 1'b1;
        if_req = 0; d_rreq = 0; d_wreq = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // Single directed transaction; cycle 0 is the cycle the request is first seen.
    task automatic do_txn(input bit dside, input logic [29:0] a, input logic [31:0] wd,
                          input bit rdq, input bit wrq);
        t_first = -1; t_lat = -1; t_rc = 0; t_wc = 0; t_ifd = 0; t_dd = 0; t_errc = 0;
        t_addr = '0; t_rdat = '0;
        if (dside) begin
            d_addr = a; d_wdata = wd; d_rreq = rdq; d_wreq = wrq;
        end else begin
            if_addr = a; if_req = 1'b1;
        end
        for (int c = 0; c < 40 && t_lat < 0; c++) begin
            @(negedge clk);
            if (mem_rreq || mem_wreq) begin
                if (t_first < 0) begin t_first = c; t_addr = mem_address; end
                if (mem_rreq) t_rc++;
                if (mem_wreq) t_wc++;
            end
            if (if_done || d_done) begin
                t_lat = c;
                if (if_done) t_ifd++;
                if (d_done) t_dd++;
                if (err) t_errc++;
                t_rdat = dside ? d_rdata : if_rdata;
            end
        end
        @(posedge clk); #1;
        if_req = 0; d_rreq = 0; d_wreq = 0;
        repeat (3) begin
            @(negedge clk);
            if (if_done) t_ifd++;
            if (d_done) t_dd++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drv_fetch(input int n);
        int s0; bit got;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if_addr = 30'($urandom); if_req = 1'b1; s0 = starts[0]; got = 0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(posedge clk); #1;
                if (if_done) got = 1;
                else if (starts[0] != s0 && $urandom_range(0, 3) == 0) if_req = 1'b0;
            end
            check("fetch_completes", 32'(got), 32'd1);
            if_req = 1'b0;
        end
    endtask

    task automatic drv_data(input int n);
        int s0; int mode; bit got;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            mode = int'($urandom_range(0, 2));
            d_addr = 30'($urandom); d_wdata = $urandom;
            d_rreq = (mode != 1); d_wreq = (mode != 0); s0 = starts[1]; got = 0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(posedge clk); #1;
                if (d_done) got = 1;
                else if (starts[1] != s0 && $urandom_range(0, 3) == 0) begin
                    d_rreq = 1'b0; d_wreq = 1'b0;
                end
            end
            check("data_completes", 32'(got), 32'd1);
            d_rreq = 1'b0; d_wreq = 1'b0;
        end
    endtask

    initial begin : main
        bit seen;
        int dones;
        rst = 1'b1; if_req = 0; if_addr = '0; d_rreq = 0; d_wreq = 0; d_addr = '0; d_wdata = '0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_write_data", mem_write_data, 32'd0);
        check("rst_ctrl", 32'({if_done, d_done, err, mem_rreq, mem_wreq}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Fetch read, ack in the first busy cycle.
        force_k = 1; use_force_rd = 1; force_rd = 32'h8C010004;
        do_txn(0, 30'h10, 32'h0, 0, 0);
        check("f_first_rreq", 32'(t_first), 32'd1);
        check("f_addr", 32'(t_addr), 32'h40);
        check("f_rreq_cycles", 32'(t_rc), 32'd1);
        check("f_latency", 32'(t_lat), 32'd2);
        check("f_if_done", 32'(t_ifd), 32'd1);
        check("f_no_d_done", 32'(t_dd), 32'd0);
        check("f_rdata", t_rdat, 32'h8C010004);

        // Data write.
        force_k = 2;
        do_txn(1, 30'h3, 32'h12345678, 0, 1);
        check("w_wreq_cycles", 32'(t_wc), 32'd2);
        check("w_no_rreq", 32'(t_rc), 32'd0);
        check("w_addr", 32'(t_addr), 32'hC);
        check("w_d_done", 32'(t_dd), 32'd1);
        check("w_no_if_done", 32'(t_ifd), 32'd0);
        check("w_latency", 32'(t_lat), 32'd3);

        // Read and write both requested: behaves as a write; high address bits dropped.
        force_k = 1; force_rd = 32'h0BAD0BAD;
        do_txn(1, 30'h3E000005, 32'hCAFEF00D, 1, 1);
        check("rw_is_write", 32'(t_wc), 32'd1);
        check("rw_no_rreq", 32'(t_rc), 32'd0);
        check("rw_addr_hi_dropped", 32'(t_addr), 32'h14);
        check("rw_d_rdata_held", t_rdat, 32'd0);

        // Timeout: ack never comes.
        force_k = 99; use_force_rd = 0;
        do_txn(1, 30'h20, 32'h0, 1, 0);
        check("to_rreq_cycles", 32'(t_rc), 32'd4);
        check("to_latency", 32'(t_lat), 32'd5);
        check("to_err", 32'(t_errc), 32'd1);
        check("to_rdata", t_rdat, 32'hDEADBEEF);

        // Ack coincides with the timeout cycle.
        force_k = 4; use_force_rd = 1; force_rd = 32'hA5A55A5A;
        do_txn(1, 30'h21, 32'h0, 1, 0);
        check("tie_latency", 32'(t_lat), 32'd5);
        check("tie_err", 32'(t_errc), 32'd0);
        check("tie_rdata", t_rdat, 32'hA5A55A5A);

        // Both sides held through three transactions after reset.
        apply_reset();
        force_k = 1; use_force_rd = 0;
        if_addr = 30'h100; d_addr = 30'h200; if_req = 1; d_rreq = 1; d_wreq = 0;
        repeat (9) begin @(posedge clk); #1; end
        if_req = 0; d_rreq = 0;
        repeat (4) begin @(posedge clk); #1; end
        check("rr_count", 32'(grant_log.size()), 32'd3);
        check("rr_grant0", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFFFFFF, 32'd0);
        check("rr_grant1", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFFFFFFFF, 32'd1);
        check("rr_grant2", (grant_log.size() > 2) ? 32'(grant_log[2]) : 32'hFFFFFFFF, 32'd0);

        // Reset in the middle of a busy read.
        force_k = 99;
        if_addr = 30'h55; if_req = 1; seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_rreq) seen = 1;
        end
        check("rst_busy_reached", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; if_req = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_rreq", 32'(mem_rreq), 32'd0);
        check("rst_busy_wreq", 32'(mem_wreq), 32'd0);
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_done || d_done) dones++;
        end
        check("rst_busy_no_done", 32'(dones), 32'd0);
        @(posedge clk); #1;
        force_k = 1; use_force_rd = 1; force_rd = 32'h13572468;
        do_txn(0, 30'h7, 32'h0, 0, 0);
        check("after_rst_latency", 32'(t_lat), 32'd2);
        check("after_rst_rdata", t_rdat, 32'h13572468);

        // Randomized concurrent traffic.
        force_k = 0; use_force_rd = 0;
        fork
            drv_fetch(40);
            drv_data(40);
        join
        repeat (12) begin @(posedge clk); #1; end
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: number of busy cycles without mem_ack before a transaction aborts.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-004 SHALL have port if_req, input, 1: instruction-fetch read request, held until if_done.
REQ-005 SHALL have port if_addr, input, 30: fetch word address.
REQ-006 SHALL have ports if_rdata (output, 32: fetch read data) and if_done (output, 1: one-cycle completion pulse).
REQ-007 SHALL have ports d_rreq and d_wreq (input, 1 each: data read and write requests, held until d_done), d_addr (input, 30: data word address) and d_wdata (input, 32: write data).
REQ-008 SHALL have ports d_rdata (output, 32), d_done (output, 1) and err (output, 1: high together with a done pulse when the transaction timed out).
REQ-009 SHALL have ports mem_address (output, 27: byte address), mem_write_data (output, 32), mem_read_data (input, 32), mem_rreq (output, 1), mem_wreq (output, 1) and mem_ack (input, 1: memory completion, one cycle).

Function
REQ-010 SHALL implement the states IDLE, FETCH, DREAD, DWRITE and RESP.
REQ-011 IDLE: SHALL sample requests each cycle and, on a grant, register the address, write data and requester, then enter FETCH, DREAD or DWRITE at the next edge.
REQ-012 Arbitration SHALL be round-robin on a last_grant bit, with fetch and data as the two requesters; if_req and d_* both high grants the side not served last; last_grant resets to data, so fetch wins the first tie.
REQ-013 When d_rreq and d_wreq are both high, the transaction SHALL be a write.
REQ-014 mem_address SHALL equal {latched_addr[24:0], 2'b00}; address bits [29:25] SHALL be ignored.
REQ-015 mem_rreq SHALL be high exactly in FETCH and DREAD, and mem_wreq exactly in DWRITE; mem_write_data SHALL be the latched d_wdata and stay stable while busy.
REQ-016 In a busy state, mem_ack high SHALL capture mem_read_data (reads only) into the granted side's rdata register and move to RESP.
REQ-017 RESP SHALL assert the granted side's done for exactly one cycle, then return to IDLE; RESP SHALL NOT grant.
REQ-018 Minimum latency SHALL be: request sampled in cycle 0, mem_*req high in cycle 1; ack in cycle 1 gives done in cycle 2.
REQ-019 A busy-cycle counter SHALL clear on entering a busy state and increment each busy cycle; when it reaches TIMEOUT without ack, the FSM SHALL enter RESP with err=1, and a read SHALL return rdata 32'hDEADBEEF.
REQ-020 If mem_ack and the timeout fall in the same cycle, ack SHALL win and err SHALL stay 0.
REQ-021 Deasserting a request mid-transaction SHALL NOT abort it; done SHALL still pulse.
REQ-022 if_rdata and d_rdata SHALL hold their last captured values until the next completion for that side.
REQ-023 mem_ack outside a busy state SHALL be ignored.

Reset
REQ-024 rst SHALL force state IDLE, last_grant=data, counter=0, and all done/err/mem_rreq/mem_wreq low at the next edge.
REQ-025 rst SHALL clear if_rdata, d_rdata, mem_address and mem_write_data to 0.
REQ-026 rst during a busy state SHALL abandon the transaction with no done pulse.

Structure
REQ-027 The state enum and the abort pattern 32'hDEADBEEF SHALL reside in shared package mem_pkg.
REQ-028 Arbitration SHALL be a sub-module rr_arb2: 2 requests, a last_grant register, and a one-hot grant output.

Verification
REQ-029 Fetch read at if_addr=0x10, ack one cycle later, mem_read_data=0x8C010004: mem_address=0x40, mem_rreq high for one cycle, if_done pulse, if_rdata=0x8C010004.
REQ-030 Data write at d_addr=0x3, d_wdata=0x12345678: mem_wreq high, mem_address=0xC, d_done pulse, no if_done.
REQ-031 if_req and d_rreq held high through three transactions: grants fetch, data, fetch.
REQ-032 TIMEOUT=4 with ack never sent: d_done and err high together four busy cycles after mem_rreq, d_rdata=0xDEADBEEF.
REQ-033 rst asserted while mem_rreq is high: mem_rreq low next cycle, no done pulse, state IDLE.
REQ-034 Ack arrives in the same cycle as the timeout: done with err=0 and the real data captured.
